// File: rtl/danger_detector.sv
// rtl/danger_detector.sv - synchronise, debounce and minimum-hold the raw danger sensor
// Rise/fall event pulses and a saturating count of rejected glitches are also produced.
module danger_detector #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 32,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_raw,
  input  logic       enable,
  output logic       danger,
  output logic       danger_rise,
  output logic       danger_fall,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;

  localparam logic [CNT_W-1:0] DEB  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       deb_q, deb_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic                   danger_q, danger_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             glitch_q, glitch_d;

  logic                   s;
  logic [CNT_W-1:0]       hold_dec;
  logic [CNT_W-1:0]       deb_inc;
  logic [7:0]             glitch_inc;

  assign s          = sync_q[SYNC_STAGES-1];
  assign hold_dec   = (hold_q != '0) ? hold_q - ONE : '0;
  assign deb_inc    = (deb_q >= DEB) ? DEB : deb_q + ONE;
  assign glitch_inc = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    deb_d    = deb_q;
    hold_d   = hold_q;
    danger_d = danger_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    if (!enable) begin
      state_d  = IDLE;
      deb_d    = '0;
      hold_d   = '0;
      danger_d = 1'b0;
      fall_d   = danger_q;
    end else begin
      case (state_q)
        IDLE: begin
          danger_d = 1'b0;
          hold_d   = '0;
          deb_d    = '0;
          if (s) begin
            // A one-cycle debounce qualifies on the very first high sample.
            if (ONE >= DEB) begin
              state_d  = ACTIVE;
              danger_d = 1'b1;
              rise_d   = 1'b1;
              hold_d   = HOLD;
            end else begin
              state_d = ARMING;
              deb_d   = ONE;
            end
          end
        end
        ARMING: begin
          if (s) begin
            if (deb_inc >= DEB) begin
              state_d  = ACTIVE;
              danger_d = 1'b1;
              rise_d   = 1'b1;
              hold_d   = HOLD;
              deb_d    = '0;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            state_d  = IDLE;
            deb_d    = '0;
            glitch_d = glitch_inc;
          end
        end
        ACTIVE: begin
          hold_d = hold_dec;
          deb_d  = '0;
          if (!s) begin
            if (ONE >= DEB && hold_dec == '0) begin
              state_d  = IDLE;
              danger_d = 1'b0;
              fall_d   = 1'b1;
            end else begin
              state_d = RELEASING;
              deb_d   = ONE;
            end
          end
        end
        RELEASING: begin
          hold_d = hold_dec;
          if (s) begin
            // Bounce back high: hold time keeps running, release debounce restarts.
            state_d  = ACTIVE;
            deb_d    = '0;
            glitch_d = glitch_inc;
          end else if (deb_inc == DEB && hold_dec == '0) begin
            state_d  = IDLE;
            deb_d    = '0;
            danger_d = 1'b0;
            fall_d   = 1'b1;
          end else begin
            deb_d = deb_inc;
          end
        end
        default: begin
          state_d  = IDLE;
          deb_d    = '0;
          hold_d   = '0;
          danger_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      deb_q    <= '0;
      hold_q   <= '0;
      danger_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 8'h00;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
      state_q  <= state_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
      danger_q <= danger_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign danger      = danger_q;
  assign danger_rise = rise_q;
  assign danger_fall = fall_q;
  assign glitch_cnt  = glitch_q;

endmodule
